// File: rtl/iterative_shifter.sv
// Iterative barrel-less shifter: one 1-bit shift/rotate step per clock until the count reaches zero.
// Define SHIFTER_CARRY_EN to add the carry_out port (last bit shifted or rotated out).
module iterative_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
`ifdef SHIFTER_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam logic [2:0] OpShr  = 3'b000;
    localparam logic [2:0] OpShra = 3'b001;
    localparam logic [2:0] OpShl  = 3'b010;
    localparam logic [2:0] OpRor  = 3'b011;
    localparam logic [2:0] OpRol  = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_val;
    logic               step_bit;
    logic               accept;

    // Only the low SHAMT_W bits of b matter; the rest is intentionally dropped.
    logic unused_b;
    assign unused_b = ^b[WIDTH-1:SHAMT_W];

`ifdef SHIFTER_CARRY_EN
    logic carry_q, carry_d;
`else
    logic unused_step_bit;
    assign unused_step_bit = step_bit;
`endif

    always_comb begin
        step_val = result_q;
        step_bit = 1'b0;
        case (op_q)
            OpShr: begin
                step_val = {1'b0, result_q[WIDTH-1:1]};
                step_bit = result_q[0];
            end
            OpShra: begin
                step_val = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                step_bit = result_q[0];
            end
            OpShl: begin
                step_val = {result_q[WIDTH-2:0], 1'b0};
                step_bit = result_q[WIDTH-1];
            end
            OpRor: begin
                step_val = {result_q[0], result_q[WIDTH-1:1]};
                step_bit = result_q[0];
            end
            OpRol: begin
                step_val = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
                step_bit = result_q[WIDTH-1];
            end
            default: begin
                step_val = result_q;
                step_bit = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept   = 1'b0;
`ifdef SHIFTER_CARRY_EN
        carry_d  = carry_q;
`endif
        case (state_q)
            StIdle: begin
                accept = start;
            end
            StShift: begin
                if (count_q != '0) begin
                    result_d = step_val;
                    count_d  = count_q - SHAMT_W'(1);
`ifdef SHIFTER_CARRY_EN
                    carry_d  = step_bit;
`endif
                end else begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                accept  = start;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Pass ops (101-111) load a count of zero so result simply becomes a.
        if (accept) begin
            state_d  = StShift;
            result_d = a;
            count_d  = (op <= OpRol) ? b[SHAMT_W-1:0] : '0;
            op_d     = op;
            busy_d   = 1'b1;
`ifdef SHIFTER_CARRY_EN
            carry_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= StIdle;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SHIFTER_CARRY_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SHIFTER_CARRY_EN
            carry_q  <= carry_d;
`endif
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
`ifdef SHIFTER_CARRY_EN
    assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: hand-computed results, latencies, abort and back-to-back.
module tb_iterative_shifter;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
`ifdef SHIFTER_CARRY_EN
    logic         carry_out;
`endif

    int checks   = 0;
    int failures = 0;

    iterative_shifter #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done)
`ifdef SHIFTER_CARRY_EN
        ,
        .carry_out(carry_out)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle. n is the effective shift count.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_res, input int n,
                          input logic exp_c, input bit mid_pulse);
        int edges;
        int busy_cycles;
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Inputs change after the accepting edge and must have no effect.
        op = ~o; a = ~av; b = bv + 3;
        check({tag, " busy_at_accept"}, W'(busy), W'(1));
        check({tag, " done_at_accept"}, W'(done), W'(0));
        busy_cycles = 1;
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clock); #1;
            edges++;
            if (mid_pulse && edges == 1) begin
                start = 1'b1; a = 32'h0; op = 3'b100; b = 32'd7;
            end
            if (mid_pulse && edges == 2) start = 1'b0;
            if (busy) busy_cycles++;
            if (busy && done) check({tag, " busy_and_done"}, W'(busy & done), W'(0));
        end
        check({tag, " done_latency"}, W'(edges), W'(n + 1));
        check({tag, " busy_cycles"}, W'(busy_cycles), W'(n + 1));
        check({tag, " result"}, result, exp_res);
        check({tag, " busy_at_done"}, W'(busy), W'(0));
`ifdef SHIFTER_CARRY_EN
        check({tag, " carry"}, W'(carry_out), W'(exp_c));
`else
        if (exp_c === 1'bx) $display("unreachable");
`endif
        @(posedge clock); #1;
        check({tag, " done_one_cycle"}, W'(done), W'(0));
        check({tag, " result_hold"}, result, exp_res);
    endtask

    initial begin
        int edges;
        int done_seen;

        // Reset state while clear is held.
        #2;
        check("reset result", result, W'(0));
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
`ifdef SHIFTER_CARRY_EN
        check("reset carry", W'(carry_out), W'(0));
`endif
        op = 3'b010; a = 32'h5; b = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        check("start_during_clear ignored", W'(busy), W'(0));

        run_op("shr",    3'b000, 32'hF0000000, 32'd4,  32'h0F000000, 4,  1'b0, 1'b0);
        run_op("shra",   3'b001, 32'hF0000000, 32'd4,  32'hFF000000, 4,  1'b0, 1'b0);
        run_op("shl28",  3'b010, 32'h0000000F, 32'd28, 32'hF0000000, 28, 1'b0, 1'b0);
        run_op("rol",    3'b100, 32'h80000001, 32'd1,  32'h00000003, 1,  1'b1, 1'b0);
        run_op("ror36",  3'b011, 32'h00000001, 32'd36, 32'h10000000, 4,  1'b0, 1'b0);
        run_op("shr_b0", 3'b000, 32'h12345678, 32'd0,  32'h12345678, 0,  1'b0, 1'b0);
        run_op("rol_b0", 3'b100, 32'h12345678, 32'd0,  32'h12345678, 0,  1'b0, 1'b0);
        run_op("pass5",  3'b101, 32'h12345678, 32'd3,  32'h12345678, 0,  1'b0, 1'b0);
        run_op("pass7",  3'b111, 32'h12345678, 32'd31, 32'h12345678, 0,  1'b0, 1'b0);
        run_op("shr1",   3'b000, 32'hFFFFFFFF, 32'd1,  32'h7FFFFFFF, 1,  1'b1, 1'b0);
        run_op("shl31",  3'b010, 32'h00000001, 32'd31, 32'h80000000, 31, 1'b0, 1'b0);
        run_op("shra31", 3'b001, 32'h80000000, 32'd31, 32'hFFFFFFFF, 31, 1'b0, 1'b0);
        run_op("shr_mid_start", 3'b000, 32'hF0000000, 32'd4, 32'h0F000000, 4, 1'b0, 1'b1);

        // Abort: SHR by 31, spurious start mid-shift, clear 10 edges after accept.
        op = 3'b000; a = 32'hFFFFFFFF; b = 32'd31; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1; a = 32'h0; op = 3'b010; b = 32'd1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("abort pre_clear result", result, 32'h003FFFFF);
        check("abort pre_clear busy", W'(busy), W'(1));
        #2;
        clear = 1'b1;
        #1;
        check("abort result", result, W'(0));
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
`ifdef SHIFTER_CARRY_EN
        check("abort carry", W'(carry_out), W'(0));
`endif
        @(negedge clock);
        clear = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) done_seen++;
        end
        check("abort no_done", W'(done_seen), W'(0));
        check("abort idle busy", W'(busy), W'(0));
        run_op("after_abort", 3'b000, 32'h00000002, 32'd1, 32'h00000001, 1, 1'b0, 1'b0);

        // Back-to-back: start held high, second op accepted on the DONE-exit edge.
        op = 3'b010; a = 32'h1; b = 32'd2; start = 1'b1;
        @(posedge clock); #1;
        op = 3'b000; a = 32'h100; b = 32'd4;
        check("b2b first busy", W'(busy), W'(1));
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
        check("b2b first latency", W'(edges), W'(3));
        check("b2b first result", result, 32'h4);
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b done_not_twice", W'(done), W'(0));
        check("b2b second busy", W'(busy), W'(1));
        check("b2b second load", result, 32'h100);
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clock); #1;
            edges++;
        end
        check("b2b second latency", W'(edges), W'(5));
        check("b2b second result", result, 32'h10);
        @(posedge clock); #1;
        check("b2b second done_one_cycle", W'(done), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
